sa_tile_ctrl: RTL and testbench

Tile sequencer for the systolic-array core. It accepts one tile command (accumulation depth K), joins paired activation/weight vector streams into the core's input ports and qualifies them with `inpvalid`. It then waits for the core's per-row results, serialises them row by row onto a single result stream, and acknowledges the core with `outread`. It sits between the operand buffers and the core, and is the only driver of the core's input side.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_row_serializer.sv | 68 ++++++
 rtl/sa_tile_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sa_tile_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array tile sequencer and its bench.
package sa_pkg;

  localparam int SA_ROWS = 8;
  localparam int SA_DW   = 8;
  localparam int SA_ACCW = 32;
  localparam int SA_KW   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sa_tile_state_t;

  typedef logic [SA_DW-1:0] sa_vec_t [SA_ROWS];

  // Default WAIT budget: two full passes over a rows x rows array.
  function automatic int sa_tmo(input int rows);
    return 2 * rows * rows;
  endfunction

endpackage

// File: rtl/sa_row_serializer.sv
// Walks the core's per-row results in order and presents them on one
// valid/ready result stream while enabled; parked at row 0 otherwise.
module sa_row_serializer
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int ACCW = SA_ACCW
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [ACCW-1:0]         core_rout [ROWS],
  input  logic [ROWS-1:0]         core_rvalid,
  input  logic                    r_ready,
  output logic                    r_valid,
  output logic [ACCW-1:0]         r_data,
  output logic [$clog2(ROWS)-1:0] r_row,
  output logic                    last_hs
);

  localparam int            RW       = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic          hs_s;

  assign hs_s    = en & core_rvalid[row_q] & r_ready;
  assign last_hs = hs_s & (row_q == LAST_ROW);

  // Next row index: advances on each accepted word, wraps after the last row.
  always_comb begin
    row_d = row_q;
    if (!en) begin
      row_d = '0;
    end else if (hs_s) begin
      row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1'b1);
    end else begin
      row_d = row_q;
    end
  end

  // Row counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  // Result stream mux; forced to zero outside DRAIN.
  always_comb begin
    r_valid = 1'b0;
    r_data  = '0;
    r_row   = '0;
    if (en) begin
      r_valid = core_rvalid[row_q];
      r_data  = core_rout[row_q];
      r_row   = row_q;
    end else begin
      r_valid = 1'b0;
      r_data  = '0;
      r_row   = '0;
    end
  end

endmodule

// File: rtl/sa_tile_ctrl.sv
// Tile sequencer: feeds K joined activation/weight beats into the core, waits
// for row results (with timeout), then drains them through sa_row_serializer.
module sa_tile_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int DW   = SA_DW,
  parameter int ACCW = SA_ACCW,
  parameter int KW   = SA_KW,
  parameter int TMO  = sa_tmo(ROWS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [KW-1:0]           klen,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ROWS*DW-1:0]      a_data,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [ROWS*DW-1:0]      w_data,
  output logic [DW-1:0]           core_a [ROWS],
  output logic [DW-1:0]           core_w [ROWS],
  output logic                    core_inpvalid,
  output logic                    core_outread,
  input  logic [ACCW-1:0]         core_rout [ROWS],
  input  logic [ROWS-1:0]         core_rvalid,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [ACCW-1:0]         r_data,
  output logic [$clog2(ROWS)-1:0] r_row
);

  sa_tile_state_t state_q;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_q;
  logic [KW-1:0]  tmo_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic           inpvalid_q;
  logic           outread_q;
  logic [DW-1:0]  core_a_q [ROWS];
  logic [DW-1:0]  core_w_q [ROWS];

  logic           feed_s;
  logic           drain_s;
  logic           beat_s;
  logic           last_hs_s;

  // Each stream is ready only when its partner is valid, so beats transfer jointly.
  assign feed_s  = (state_q == ST_FEED);
  assign drain_s = (state_q == ST_DRAIN);
  assign a_ready = feed_s & w_valid;
  assign w_ready = feed_s & a_valid;
  assign beat_s  = feed_s & a_valid & w_valid;

  // Tile FSM with feed registers, beat/timeout counters and registered status.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inpvalid_q <= 1'b0;
      outread_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        core_a_q[r] <= '0;
        core_w_q[r] <= '0;
      end
    end else begin
      inpvalid_q <= 1'b0;
      done_q     <= 1'b0;
      outread_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (klen != '0)) begin
            k_q     <= klen;
            beat_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (beat_s) begin
            for (int r = 0; r < ROWS; r++) begin
              core_a_q[r] <= a_data[r*DW +: DW];
              core_w_q[r] <= w_data[r*DW +: DW];
            end
            inpvalid_q <= 1'b1;
            beat_q     <= beat_q + KW'(1'b1);
            if (beat_q == (k_q - KW'(1'b1))) begin
              tmo_q   <= '0;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (|core_rvalid) begin
            state_q <= ST_DRAIN;
          end else if (tmo_q == KW'(TMO - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + KW'(1'b1);
          end
        end
        ST_DRAIN: begin
          if (last_hs_s) begin
            outread_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign core_inpvalid = inpvalid_q;
  assign core_outread  = outread_q;
  assign core_a        = core_a_q;
  assign core_w        = core_w_q;

  sa_row_serializer #(
    .ROWS (ROWS),
    .ACCW (ACCW)
  ) u_ser (
    .clk         (clk),
    .rstn        (rstn),
    .en          (drain_s),
    .core_rout   (core_rout),
    .core_rvalid (core_rvalid),
    .r_ready     (r_ready),
    .r_valid     (r_valid),
    .r_data      (r_data),
    .r_row       (r_row),
    .last_hs     (last_hs_s)
  );

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Self-checking bench for sa_tile_ctrl: handshake vector table, directed
// corner sequences and randomized tiles against a transaction-level model.
module tb_sa_tile_ctrl;
  import sa_pkg::*;

  localparam int ROWS = SA_ROWS;
  localparam int DW   = SA_DW;
  localparam int ACCW = SA_ACCW;
  localparam int KW   = SA_KW;
  localparam int TMO  = 2 * ROWS * ROWS;
  localparam int RW   = $clog2(ROWS);
  localparam int VW   = ROWS * DW;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   klen = '0;
  logic            busy, done, err;
  logic            a_valid = 1'b0, w_valid = 1'b0;
  logic            a_ready, w_ready;
  logic [VW-1:0]   a_data = '0, w_data = '0;
  sa_vec_t         core_a, core_w;
  logic            core_inpvalid, core_outread;
  logic [ACCW-1:0] core_rout [ROWS];
  logic [ROWS-1:0] core_rvalid = '0;
  logic            r_valid;
  logic            r_ready = 1'b0;
  logic [ACCW-1:0] r_data;
  logic [RW-1:0]   r_row;

  always #5 clk = ~clk;

  sa_tile_ctrl #(.ROWS(ROWS), .DW(DW), .ACCW(ACCW), .KW(KW), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .klen(klen),
    .busy(busy), .done(done), .err(err),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .core_a(core_a), .core_w(core_w),
    .core_inpvalid(core_inpvalid), .core_outread(core_outread),
    .core_rout(core_rout), .core_rvalid(core_rvalid),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_row(r_row)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Observations collected once per cycle.
  logic [VW-1:0]   obs_a [$];
  logic [VW-1:0]   obs_w [$];
  int              beat_cyc [$];
  logic [ACCW-1:0] res_d [$];
  int              res_r [$];
  int              done_cnt, outr_cnt, outr_cyc, last_hs_cyc;
  logic            xfer_s;
  logic            rv_clear = 1'b0;
  logic            stall_p = 1'b0;
  logic [ACCW-1:0] stall_d;
  logic [RW-1:0]   stall_r;

  typedef struct {
    logic          av;
    logic          wv;
    logic [DW-1:0] d;
    logic          ar;
    logic          wr;
    logic          iv;
    logic [DW-1:0] a0;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] b);
    logic [VW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = b;
    return v;
  endfunction

  task automatic clear_mon();
    obs_a.delete(); obs_w.delete(); beat_cyc.delete();
    res_d.delete(); res_r.delete();
    done_cnt = 0; outr_cnt = 0; outr_cyc = -1; last_hs_cyc = -1;
  endtask

  // Mid-cycle monitor: records beats, results, pulses; checks stall stability.
  task automatic sample();
    logic [VW-1:0] pa, pw;
    cyc++;
    xfer_s = 1'b0;
    if (!rstn) begin
      stall_p = 1'b0;
      return;
    end
    if (core_inpvalid) begin
      for (int r = 0; r < ROWS; r++) begin
        pa[r*DW +: DW] = core_a[r];
        pw[r*DW +: DW] = core_w[r];
      end
      obs_a.push_back(pa); obs_w.push_back(pw); beat_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (core_outread) begin
      outr_cnt++; outr_cyc = cyc; rv_clear = 1'b1;
    end
    xfer_s = a_valid & a_ready;
    if (stall_p) begin
      chk("stall_data", r_data, stall_d);
      chk("stall_row", r_row, stall_r);
    end
    if (r_valid && r_ready) begin
      res_d.push_back(r_data); res_r.push_back(int'(r_row)); last_hs_cyc = cyc;
    end
    stall_p = r_valid & ~r_ready;
    stall_d = r_data;
    stall_r = r_row;
  endtask

  task automatic half_a();
    @(negedge clk);
    sample();
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
    if (rv_clear) begin
      core_rvalid = '0;
      rv_clear = 1'b0;
    end
  endtask

  task automatic step();
    half_a();
    half_b();
  endtask

  task automatic start_tile(input int k);
    start = 1'b1; klen = KW'(k);
    step();
    start = 1'b0; klen = '0;
  endtask

  task automatic feed_one(input logic [DW-1:0] b);
    a_valid = 1'b1; w_valid = 1'b1; a_data = fill(b); w_data = fill(~b);
    step();
    a_valid = 1'b0; w_valid = 1'b0;
  endtask

  // Core presents 100+r on every row; drain and check order, pulses and timing.
  task automatic drain_tile(input int mode, input string tag, input bit hold_start);
    bit seen = 1'b0;
    res_d.delete(); res_r.delete();
    done_cnt = 0; outr_cnt = 0; outr_cyc = -1; last_hs_cyc = -1;
    for (int r = 0; r < ROWS; r++) core_rout[r] = ACCW'(100 + r);
    core_rvalid = '1;
    if (hold_start) begin
      start = 1'b1; klen = KW'(1);
    end
    for (int j = 0; j < 200 && !seen; j++) begin
      r_ready = (mode == 0) ? 1'b1 : (j % 2 == 1);
      half_a();
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, busy, 1'b0);
      end
      half_b();
    end
    r_ready = 1'b0;
    chk({tag, "_done_seen"}, seen, 1'b1);
    chk({tag, "_nres"}, res_d.size(), ROWS);
    for (int i = 0; i < res_d.size() && i < ROWS; i++) begin
      chk($sformatf("%s_row%0d", tag, i), res_r[i], i);
      chk($sformatf("%s_data%0d", tag, i), res_d[i], 100 + i);
    end
    chk({tag, "_outread_cnt"}, outr_cnt, 1);
    chk({tag, "_outread_after_last"}, outr_cyc, last_hs_cyc + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic rand_tile(input int t);
    logic [VW-1:0]   A [$];
    logic [VW-1:0]   W [$];
    logic [ACCW-1:0] rv [ROWS];
    int k    = $urandom_range(1, 6);
    int dly  = $urandom_range(0, 5);
    int idx  = 0;
    int wcnt = 0;
    bit seen = 1'b0;
    clear_mon();
    for (int i = 0; i < k; i++) begin
      A.push_back({$urandom, $urandom});
      W.push_back({$urandom, $urandom});
    end
    for (int r = 0; r < ROWS; r++) begin
      rv[r] = $urandom;
      core_rout[r] = rv[r];
    end
    start_tile(k);
    for (int j = 0; j < 600 && !seen; j++) begin
      a_valid = (idx < k) && ($urandom_range(0, 3) != 0);
      w_valid = (idx < k) && ($urandom_range(0, 3) != 0);
      a_data  = (idx < k) ? A[idx] : '0;
      w_data  = (idx < k) ? W[idx] : '0;
      r_ready = $urandom_range(0, 1);
      if (obs_a.size() == k && outr_cnt == 0) begin
        if (wcnt >= dly) core_rvalid = '1;
        wcnt++;
      end
      half_a();
      seen = done;
      if (xfer_s) idx++;
      half_b();
    end
    a_valid = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
    chk($sformatf("rnd%0d_done_seen", t), seen, 1'b1);
    chk($sformatf("rnd%0d_nbeats", t), obs_a.size(), k);
    for (int i = 0; i < obs_a.size() && i < k; i++) begin
      chk($sformatf("rnd%0d_a%0d", t, i), obs_a[i], A[i]);
      chk($sformatf("rnd%0d_w%0d", t, i), obs_w[i], W[i]);
    end
    chk($sformatf("rnd%0d_nres", t), res_d.size(), ROWS);
    for (int i = 0; i < res_d.size() && i < ROWS; i++) begin
      chk($sformatf("rnd%0d_row%0d", t, i), res_r[i], i);
      chk($sformatf("rnd%0d_res%0d", t, i), res_d[i], rv[i]);
    end
    chk($sformatf("rnd%0d_outread", t), outr_cnt, 1);
    chk($sformatf("rnd%0d_done", t), done_cnt, 1);
    chk($sformatf("rnd%0d_err", t), err, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [VW-1:0] pa;
    for (int r = 0; r < ROWS; r++) pa[r*DW +: DW] = core_a[r];
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_a_ready"}, a_ready, 1'b0);
    chk({tag, "_w_ready"}, w_ready, 1'b0);
    chk({tag, "_inpvalid"}, core_inpvalid, 1'b0);
    chk({tag, "_outread"}, core_outread, 1'b0);
    chk({tag, "_r_valid"}, r_valid, 1'b0);
    chk({tag, "_r_data"}, r_data, '0);
    chk({tag, "_r_row"}, r_row, '0);
    chk({tag, "_core_a"}, pa, '0);
  endtask

  initial begin
    int done_at;
    logic err_at;
    tbl[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[2] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[3] = '{1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[4] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55};
    tbl[5] = '{1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[6] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77};
    tbl[7] = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 8'h77};
    for (int r = 0; r < ROWS; r++) core_rout[r] = '0;

    // Reset state, with both valids asserted to show readiness stays low.
    a_valid = 1'b1; w_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    a_valid = 1'b0; w_valid = 1'b0;
    rstn = 1'b1;
    step();

    // Four back-to-back beats with row data 1..4.
    clear_mon();
    start_tile(4);
    chk("t1_busy", busy, 1'b1);
    a_valid = 1'b1; w_valid = 1'b1; w_data = fill(8'hFF);
    for (int b = 0; b < 4; b++) begin
      a_data = fill(DW'(b + 1));
      step();
    end
    a_valid = 1'b0; w_valid = 1'b0;
    step(); step();
    chk("t1_nbeats", obs_a.size(), 4);
    for (int b = 0; b < obs_a.size() && b < 4; b++) begin
      chk($sformatf("t1_a0_beat%0d", b), obs_a[b][DW-1:0], b + 1);
      chk($sformatf("t1_w_beat%0d", b), obs_w[b], fill(8'hFF));
    end
    if (beat_cyc.size() == 4) chk("t1_consecutive", beat_cyc[3] - beat_cyc[0], 3);
    chk("t1_no_done_yet", done_cnt, 0);
    drain_tile(0, "t1", 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // Joint-handshake vector table with bubbles, K = 3, then stalled drain.
    clear_mon();
    start_tile(3);
    for (int i = 0; i < 8; i++) begin
      a_valid = tbl[i].av; w_valid = tbl[i].wv;
      a_data = fill(tbl[i].d); w_data = fill(~tbl[i].d);
      half_a();
      chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ar);
      chk($sformatf("tbl%0d_w_ready", i), w_ready, tbl[i].wr);
      half_b();
      chk($sformatf("tbl%0d_inpvalid", i), core_inpvalid, tbl[i].iv);
      chk($sformatf("tbl%0d_core_a0", i), core_a[0], tbl[i].a0);
    end
    a_valid = 1'b0; w_valid = 1'b0;
    chk("tbl_nbeats", obs_a.size(), 3);
    drain_tile(1, "tbl", 1'b0);

    // Timeout: the core never reports a row.
    clear_mon();
    start_tile(1);
    feed_one(8'h5A);
    done_at = 0; err_at = 1'b0;
    for (int j = 1; j <= TMO + 40; j++) begin
      half_a();
      if (j == TMO) chk("tmo_err_early", err, 1'b0);
      if (done) begin
        done_at = j; err_at = err;
      end
      half_b();
      if (done_at != 0) break;
    end
    chk("tmo_done_cycle", done_at, TMO + 1);
    chk("tmo_err_at_done", err_at, 1'b1);
    chk("tmo_outread", outr_cnt, 0);
    chk("tmo_done_cnt", done_cnt, 1);
    step();
    chk("tmo_err_sticky", err, 1'b1);
    start_tile(1);
    chk("tmo_err_cleared", err, 1'b0);
    feed_one(8'h5B);
    drain_tile(0, "tmo2", 1'b0);

    // Ignored commands: klen = 0, start while busy, start in the DONE cycle.
    clear_mon();
    start = 1'b1; klen = '0;
    step();
    start = 1'b0;
    chk("ign_k0_busy", busy, 1'b0);
    step();
    chk("ign_k0_busy2", busy, 1'b0);
    start_tile(2);
    a_valid = 1'b1; w_valid = 1'b1; a_data = fill(8'h31);
    start = 1'b1; klen = KW'(5);
    step();
    start = 1'b0; a_data = fill(8'h32);
    step();
    a_data = fill(8'h33);
    step(); step();
    a_valid = 1'b0; w_valid = 1'b0;
    chk("ign_nbeats", obs_a.size(), 2);
    if (obs_a.size() >= 2) chk("ign_beat2", obs_a[1], fill(8'h32));
    chk("ign_busy", busy, 1'b1);
    drain_tile(0, "ign", 1'b1);
    chk("ign_done_start_busy", busy, 1'b0);
    step();
    start = 1'b0; klen = '0;
    chk("ign_late_start_busy", busy, 1'b1);
    feed_one(8'h44);
    drain_tile(0, "ign2", 1'b0);

    // Asynchronous reset in the middle of DRAIN.
    clear_mon();
    start_tile(1);
    feed_one(8'h5A);
    for (int r = 0; r < ROWS; r++) core_rout[r] = ACCW'(100 + r);
    core_rvalid = '1; r_ready = 1'b1;
    for (int j = 0; j < 50 && res_d.size() < 3; j++) step();
    r_ready = 1'b0;
    chk("rst_at_row3", r_row, 3);
    rstn = 1'b0;
    #1;
    check_all_zero("rst_async");
    step(); step();
    chk("rst_no_done", done_cnt, 0);
    core_rvalid = '0;
    rstn = 1'b1;
    step();
    clear_mon();
    start_tile(2);
    feed_one(8'h61);
    feed_one(8'h62);
    step();
    chk("rst_new_nbeats", obs_a.size(), 2);
    drain_tile(0, "post_rst", 1'b0);

    // Randomized tiles against the transaction-level model.
    for (int t = 0; t < 12; t++) begin
      rand_tile(t);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
